// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csel_pkg;
    localparam int SLICE_W = 4;

    typedef logic [SLICE_W-1:0] slice_t;

    function automatic int csel_stages(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/adder_select_4_bit.sv
// 4-bit carry-select slice: both carry outcomes are precomputed and sel_in picks one.
module adder_select_4_bit (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       sel_in,
    output logic [3:0] s_out,
    output logic       c_out
);
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;

    assign sum_c0 = {1'b0, a_in} + {1'b0, b_in};
    assign sum_c1 = {1'b0, a_in} + {1'b0, b_in} + 5'd1;
    assign {c_out, s_out} = sel_in ? sum_c1 : sum_c0;
endmodule

// File: rtl/csel_pipe_stage.sv
// One pipeline stage: adds slice K with the previous stage's carry and registers the result.
module csel_pipe_stage
    import csel_pkg::*;
#(
    parameter int K     = 0,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             rdy_dn_i,
    output logic             rdy_o,
    output logic             vld_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);
    localparam int LO  = SLICE_W * K;
    localparam int HI  = LO + SLICE_W;
    localparam int REM = WIDTH - HI;
    localparam logic [WIDTH-1:0] DONE_MASK = (WIDTH'(1) << LO) - WIDTH'(1);

    slice_t          slice_s;
    logic            slice_c;
    logic            vld_q;
    logic            carry_q;
    logic [HI-1:0]   sum_q;
    logic [HI-1:0]   sum_d;
    logic            adv;
    logic            load;

    adder_select_4_bit u_slice (
        .a_in   (a_i[LO +: SLICE_W]),
        .b_in   (b_i[LO +: SLICE_W]),
        .sel_in (carry_i),
        .s_out  (slice_s),
        .c_out  (slice_c)
    );

    assign adv   = vld_q & rdy_dn_i;
    assign rdy_o = ~vld_q | adv;
    assign load  = rdy_o & vld_i;

    // Resolved bits below LO pass through; this slice fills [HI-1:LO].
    always_comb begin
        sum_d = HI'(sum_i & DONE_MASK);
        sum_d[LO +: SLICE_W] = slice_s;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            if (rdy_o) vld_q <= vld_i;
            if (load) begin
                carry_q <= slice_c;
                sum_q   <= sum_d;
            end
        end
    end

    if (REM > 0) begin : g_operands
        logic [REM-1:0] a_q, b_q;
        logic [REM-1:0] a_d, b_d;

        assign a_d = REM'(a_i >> HI);
        assign b_d = REM'(b_i >> HI);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_q <= '0;
                b_q <= '0;
            end else if (load) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign a_o = {a_q, {HI{1'b0}}};
        assign b_o = {b_q, {HI{1'b0}}};
    end else begin : g_no_operands
        // Final slice: nothing left to carry forward.
        logic unused_lo;
        assign unused_lo = ^(a_i & DONE_MASK) ^ ^(b_i & DONE_MASK);
        assign a_o = '0;
        assign b_o = '0;
    end

    assign vld_o   = vld_q;
    assign carry_o = carry_q;
    assign sum_o   = WIDTH'(sum_q);
endmodule

// File: rtl/carry_select_pipe_adder.sv
// Pipelined unsigned adder, one 4-bit carry-select slice per stage, valid/ready on both sides.
module carry_select_pipe_adder
    import csel_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
);
    localparam int STAGES = csel_stages(WIDTH);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 2 * SLICE_W) begin : g_width_chk
        $error("carry_select_pipe_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    logic [STAGES:0]  vld_ch;
    logic [STAGES:0]  carry_ch;
    logic [WIDTH-1:0] sum_ch [STAGES+1];
    logic [WIDTH-1:0] a_ch   [STAGES+1];
    logic [WIDTH-1:0] b_ch   [STAGES+1];
    logic             unused_tail;

    assign vld_ch[0]   = valid_in;
    assign carry_ch[0] = c_in;
    assign sum_ch[0]   = '0;
    assign a_ch[0]     = a_in;
    assign b_ch[0]     = b_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic rdy_up;
        logic rdy_dn;

        // Ready ripples combinationally from the output back to stage 0.
        if (k == STAGES - 1) begin : g_tail
            assign rdy_dn = ready_in;
        end else begin : g_body
            assign rdy_dn = g_stage[k+1].rdy_up;
        end

        csel_pipe_stage #(
            .K     (k),
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i    (clk_in),
            .rst_i    (rst_in),
            .vld_i    (vld_ch[k]),
            .carry_i  (carry_ch[k]),
            .sum_i    (sum_ch[k]),
            .a_i      (a_ch[k]),
            .b_i      (b_ch[k]),
            .rdy_dn_i (rdy_dn),
            .rdy_o    (rdy_up),
            .vld_o    (vld_ch[k+1]),
            .carry_o  (carry_ch[k+1]),
            .sum_o    (sum_ch[k+1]),
            .a_o      (a_ch[k+1]),
            .b_o      (b_ch[k+1])
        );
    end

    assign ready_out   = g_stage[0].rdy_up;
    assign valid_out   = vld_ch[STAGES];
    assign s_out       = sum_ch[STAGES];
    assign c_out       = carry_ch[STAGES];
    assign unused_tail = ^{a_ch[STAGES], b_ch[STAGES]};
endmodule

// File: doc/carry_select_pipe_adder.md
# carry_select_pipe_adder

Pipelined WIDTH-bit unsigned adder. Each stage adds one 4-bit slice using the team's existing `adder_select_4_bit` block. The carry-select mux in that slice is driven by the registered carry of the previous stage. The block sits directly above the 4-bit select slices in the carry-select pipeline: it feeds each slice its operands and select carry, and it registers what each slice produces. A valid/ready handshake on both sides gives full throughput of one operation per cycle, with backpressure.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 8 (elaboration error otherwise)
- STAGES (localparam), WIDTH/4, pipeline depth
- clk_in  input  1  single clock, rising edge
- rst_in  input  1  reset, asynchronous and active-high
- valid_in  input  1  upstream offers an operation
- ready_out  output  1  block accepts an operation this cycle
- a_in  input  WIDTH  operand A, unsigned
- b_in  input  WIDTH  operand B, unsigned
- c_in  input  1  carry into bit 0
- valid_out  output  1  s_out/c_out hold a result
- ready_in  input  1  downstream accepts the result
- s_out  output  WIDTH  sum bits
- c_out  output  1  carry out of bit WIDTH-1

## Operation
- Each stage k (0..STAGES-1) has a register with these fields:
  - vld
  - carry
  - sum[4k+3:0] (sum bits resolved so far)
  - a/b bits [WIDTH-1:4k+4] (operand bits not yet added)
- Stage 0 register:
  - Loads from the inputs through slice 0, with sel_in = c_in.
  - Load condition: valid_in && ready_out.
- Stage k>0 register:
  - Loads from stage k-1 through slice k, with sel_in = stage k-1 carry.
  - Slice k takes the stage k-1 a/b bits [4k+3:4k].
  - The new sum is the slice s_out concatenated above the old sum bits; carry = slice c_out.
- Advance rule, per stage:
  - adv[k] = vld[k] && (k==STAGES-1 ? ready_in : ready[k+1]).
  - ready[k] = !vld[k] || adv[k].
  - ready_out = ready[0]. The combinational ready chain through all stages is allowed.
- vld update:
  - When ready[k]=1, vld[k] takes the upstream valid.
  - When ready[k]=0, the register holds all contents.
- Outputs:
  - valid_out = vld[STAGES-1]; s_out/c_out come from the last-stage register.
  - No combinational path from a_in/b_in/c_in to the outputs.
- Arithmetic:
  - {c_out, s_out} = a_in + b_in + c_in, modulo 2^(WIDTH+1); exact, never saturates.
  - No signed overflow flag.
- Ordering: results leave in acceptance order; no operation is dropped or duplicated.

## Timing
- Reset, asynchronous while rst_in=1:
  - All vld = 0, all data fields = 0.
  - valid_out=0, s_out=0, c_out=0.
  - ready_out=1 in the first cycle after reset deasserts.
- Latency: accepted at rising edge T → valid_out=1 after edge T+STAGES-1. With WIDTH=16, a result accepted at edge 0 is visible after edge 3.
- Throughput: 1 op/cycle while ready_in=1; back-to-back accepts need no bubbles.
- Stall, while valid_out=1 && ready_in=0:
  - s_out, c_out and valid_out stay stable.
  - Bubbles upstream still collapse (stages with vld=0 keep filling).
- Full pipeline (all vld=1) with ready_in=0: ready_out=0 in that same cycle.
- Simultaneous events:
  - With the pipeline full and ready_in=1, ready_out=1.
  - An accept and a release in the same cycle both happen.
- valid_in=1 while ready_out=0: no accept; upstream must hold a_in/b_in/c_in stable.
- Reset mid-operation: all in-flight ops are discarded immediately, with no partial output.
- Critical path: one 4-bit slice + 4-bit mux + stage register, plus the STAGES-deep ready AND/OR chain.

## Structure
- Shared package csel_pkg:
  - localparam SLICE_W = 4.
  - Function csel_stages(width) returning width/SLICE_W.
  - Parameterized-width stage-field typedef helpers where the tool allows.
- Sub-module csel_pipe_stage, parameterized by stage index K and WIDTH:
  - Contains one `adder_select_4_bit` instance, the stage register and the local ready/advance logic.
  - The top generates STAGES instances of it.

## Test plan
- Reset then 0xFFFF + 0x0001, c_in=0, ready_in=1 → after 4 cycles valid_out=1, s_out=0x0000, c_out=1; ready_out=1 right after reset.
- 0x1234 + 0x4321, c_in=1 → s_out=0x5556, c_out=0; also 0x8000+0x8000, c_in=1 → s_out=0x0001, c_out=1.
- Stream 8 ops back-to-back with ready_in=1 (a=i·0x1111, b=0x0F0F, c_in=i[0]) → 8 results on consecutive cycles, in order, all correct.
- Hold ready_in=0 and offer ops continuously:
  - Exactly 4 are accepted, then ready_out=0.
  - Outputs stay stable for 10 cycles.
  - Raising ready_in drains 4 results in order with a new accept each cycle.
- Assert rst_in asynchronously with 3 ops in flight → valid_out and s_out/c_out go to 0 immediately; no stale result appears after reset is released.
- 10k random ops with random valid_in/ready_in and WIDTH=16 and 32 → every result matches a scoreboard of a+b+c_in; count in = count out.
